// File: rtl/buffer2axis.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : buffer2axis
// Purpose  : Serialises WIDTH-bit cell rows (1 = alive) into a DWIDTH-bit
//            AXI-Stream pixel stream, one pixel per beat, bit 0 first.
//            Rows are buffered in a DEPTH-entry FIFO; TLAST marks the last
//            pixel of each HEIGHT-row frame; frame_done pulses afterwards.
// Options  : `define BUFFER2AXIS_TUSER_SOF_EN adds M_AXIS_TUSER, asserted on
//            the first pixel of every frame.
// Revision : 1.0 - initial release
// ============================================================================
module buffer2axis #(
    parameter int DWIDTH = 32,
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DWIDTH-1:0] alive_color,
    input  logic [DWIDTH-1:0] dead_color,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DWIDTH-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic              M_AXIS_TLAST,
`ifdef BUFFER2AXIS_TUSER_SOF_EN
    output logic              M_AXIS_TUSER,
`endif
    output logic              frame_done
);

    localparam int c_pix_w = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int c_row_w = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    localparam logic [c_pix_w-1:0] c_last_pix = c_pix_w'(WIDTH - 1);
    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(HEIGHT - 1);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    logic [WIDTH-1:0]    r_row_q;
    logic [c_pix_w-1:0]  r_pix_cnt;
    logic [c_row_w-1:0]  r_row_cnt;
    logic                r_frame_done;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_hs;
    logic                w_row_end;

    // FIFO status; a full FIFO refuses the push even when a pop happens the same cycle
    assign w_full     = (r_count == c_full_cnt);
    assign w_empty    = (r_count == '0);
    assign in_ready   = !w_full;
    assign w_push     = in_valid && !w_full;
    assign frame_done = r_frame_done;

    // Serializer state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, FIFO pop and stream outputs; a row end pops the next row without a bubble
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_hs          = 1'b0;
        w_row_end     = 1'b0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TDATA  = '0;
        M_AXIS_TLAST  = 1'b0;
`ifdef BUFFER2AXIS_TUSER_SOF_EN
        M_AXIS_TUSER  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TDATA  = r_row_q[r_pix_cnt] ? alive_color : dead_color;
                M_AXIS_TLAST  = (r_row_cnt == c_last_row) && (r_pix_cnt == c_last_pix);
`ifdef BUFFER2AXIS_TUSER_SOF_EN
                M_AXIS_TUSER  = (r_row_cnt == '0) && (r_pix_cnt == '0);
`endif
                if (M_AXIS_TREADY) begin
                    w_hs = 1'b1;
                    if (r_pix_cnt == c_last_pix) begin
                        w_row_end = 1'b1;
                        if (!w_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Row storage; contents are don't-care while the pointers mark it empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers/count, pixel and row counters, frame-done pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_row_q      <= '0;
            r_pix_cnt    <= '0;
            r_row_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                r_row_q  <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop || w_row_end) begin
                r_pix_cnt <= '0;
            end else if (w_hs) begin
                r_pix_cnt <= r_pix_cnt + c_pix_w'(1);
            end
            if (w_row_end) begin
                r_row_cnt <= (r_row_cnt == c_last_row) ? '0 : r_row_cnt + c_row_w'(1);
            end
            r_frame_done <= w_hs && M_AXIS_TLAST;
        end
    end

endmodule
`default_nettype wire
